// File: rtl/fft_result_reader.sv
// Streams a two-bank (even/odd) FFT result memory out in natural point order over valid/ready,
// using a 4-point FIFO with credit-controlled prefetch to hide the one-cycle bank read latency.
module fft_result_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_even_real,
    input  logic [DATA_W-1:0] i_even_imag,
    input  logic [DATA_W-1:0] i_odd_real,
    input  logic [DATA_W-1:0] i_odd_imag,
    output logic [DATA_W-1:0] o_real,
    output logic [DATA_W-1:0] o_imag,
    output logic [ADDR_W:0]   o_index,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   LAST_IDX  = {(ADDR_W + 1){1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic              rd_en_r;
    logic              ret_r;
    logic              busy_r;
    logic              done_r;
    logic              valid_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [ADDR_W:0]   idx_r;
    logic [2:0]        occ_r;
    logic [1:0]        wr_ptr_r;
    logic [1:0]        rd_ptr_r;
    logic [DATA_W-1:0] fifo_re_r [4];
    logic [DATA_W-1:0] fifo_im_r [4];

    logic              pop_s;
    logic              push_s;
    logic              can_issue_s;
    logic              drained_s;
    logic [2:0]        occ_next_s;
    logic [3:0]        load_s;
    logic [1:0]        wr_ptr_p1_s;
    logic [ADDR_W-1:0] next_addr_s;

    // Credit check: points left after this cycle's pop plus in-flight pairs; an idle sink adds one
    // so that only a single pair is prefetched while nothing is being drained.
    always_comb begin
        pop_s       = i_en & valid_r & i_ready;
        push_s      = ret_r;
        occ_next_s  = occ_r - {2'b00, pop_s} + (push_s ? 3'd2 : 3'd0);
        load_s      = {1'b0, occ_r} - {3'b000, pop_s} + {2'b00, rd_en_r, 1'b0}
                    + {2'b00, ret_r, 1'b0} + {3'b000, ~i_ready};
        can_issue_s = (load_s <= 4'd2);
        drained_s   = (occ_next_s == 3'd0) & ~rd_en_r & ~ret_r;
        wr_ptr_p1_s = wr_ptr_r + 2'd1;
        next_addr_s = rd_addr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
    end

    // Point FIFO: bank returns are always captured (memory is not enable-gated), pops need i_en.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_re_r[i] <= {DATA_W{1'b0}};
                fifo_im_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            occ_r    <= 3'd0;
            valid_r  <= 1'b0;
            idx_r    <= {(ADDR_W + 1){1'b0}};
            ret_r    <= 1'b0;
        end else begin
            ret_r <= rd_en_r;
            occ_r <= occ_next_s;
            if (push_s) begin
                fifo_re_r[wr_ptr_r]    <= i_even_real;
                fifo_im_r[wr_ptr_r]    <= i_even_imag;
                fifo_re_r[wr_ptr_p1_s] <= i_odd_real;
                fifo_im_r[wr_ptr_p1_s] <= i_odd_imag;
                wr_ptr_r               <= wr_ptr_r + 2'd2;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
                idx_r    <= idx_r + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (i_en) begin
                valid_r <= (occ_next_s != 3'd0);
            end
        end
    end

    // Pass control: the first read goes out with the start so the first beat is two cycles later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= IDLE;
            rd_en_r   <= 1'b0;
            rd_addr_r <= {ADDR_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (i_en) begin
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        state_r   <= READ;
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= {ADDR_W{1'b0}};
                        busy_r    <= 1'b1;
                    end else begin
                        rd_en_r <= 1'b0;
                    end
                end
                READ: begin
                    if (can_issue_s) begin
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= next_addr_s;
                        if (next_addr_s == LAST_ADDR) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= READ;
                        end
                    end else begin
                        rd_en_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    rd_en_r <= 1'b0;
                    if (drained_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    rd_en_r <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    rd_en_r <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end else begin
            rd_en_r <= 1'b0;
        end
    end

    assign o_busy    = busy_r;
    assign o_done    = done_r;
    assign o_rd_en   = rd_en_r;
    assign o_rd_addr = rd_addr_r;
    assign o_valid   = valid_r;
    assign o_real    = fifo_re_r[rd_ptr_r];
    assign o_imag    = fifo_im_r[rd_ptr_r];
    assign o_index   = idx_r;
    assign o_last    = valid_r & (idx_r == LAST_IDX);

endmodule

// File: tb/tb_fft_result_reader.sv
// Self-checking bench for fft_result_reader: bank memory model, beat recorder, and per-scenario tasks.
module tb_fft_result_reader;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam int NB = 1 << AW;
    localparam int NP = 2 * NB;

    logic clk = 1'b0;
    logic rst_n, en, start, ready;
    logic busy, done, rd_en, valid, last;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] er, ei, odr, odi, o_re, o_im;
    logic [AW:0]   idx;

    logic [DW-1:0] ev_re [NB];
    logic [DW-1:0] ev_im [NB];
    logic [DW-1:0] od_re [NB];
    logic [DW-1:0] od_im [NB];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t beat_q[$];
    int    rd_addr_q[$];
    int    cyc = 0;
    int    rd_cnt = 0;
    int    done_cnt = 0;
    int    done_cyc = -1;
    int    stab_err = 0;
    int    outst = 0;
    int    max_outst = 0;
    logic  hold_v = 1'b0;
    logic [AW+2*DW+1:0] hold_p = '0;
    logic  xfer;
    int    outst_nxt;

    fft_result_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start),
        .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
        .i_even_real(er), .i_even_imag(ei), .i_odd_real(odr), .i_odd_imag(odi),
        .o_real(o_re), .o_imag(o_im), .o_index(idx), .o_valid(valid),
        .i_ready(ready), .o_last(last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank memory: one-cycle read latency, independent of enable.
    always @(posedge clk) begin
        if (rd_en) begin
            er  <= ev_re[rd_addr];
            ei  <= ev_im[rd_addr];
            odr <= od_re[rd_addr];
            odi <= od_im[rd_addr];
        end
    end

    assign xfer      = en && valid && ready;
    assign outst_nxt = outst + (rd_en ? 2 : 0) - (xfer ? 1 : 0);

    // Recorder: transferred beats, issued reads, done pulses, stall stability, outstanding points.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v <= 1'b0;
            outst  <= 0;
        end else begin
            if (xfer) beat_q.push_back('{int'(idx), o_re, o_im, last, cyc});
            if (rd_en) begin
                rd_addr_q.push_back(int'(rd_addr));
                rd_cnt <= rd_cnt + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (hold_v && (!valid || {idx, o_re, o_im, last} !== hold_p)) stab_err <= stab_err + 1;
            hold_v <= valid && !(ready && en);
            hold_p <= {idx, o_re, o_im, last};
            outst  <= outst_nxt;
            if (outst_nxt > max_outst) max_outst <= outst_nxt;
        end
    end

    function automatic logic [DW-1:0] exp_re(int k);
        return (k % 2 == 1) ? od_re[k / 2] : ev_re[k / 2];
    endfunction

    function automatic logic [DW-1:0] exp_im(int k);
        return (k % 2 == 1) ? od_im[k / 2] : ev_im[k / 2];
    endfunction

    // Number of beats from position qb that differ from the natural-order reference pass.
    function automatic int seq_bad(int qb);
        int bad = 0;
        for (int i = 0; i < NP; i++) begin
            if (qb + i >= beat_q.size()) bad++;
            else if (beat_q[qb+i].idx != i || beat_q[qb+i].re !== exp_re(i) ||
                     beat_q[qb+i].im !== exp_im(i) || beat_q[qb+i].last !== (i == NP - 1)) bad++;
        end
        return bad;
    endfunction

    function automatic int rd_bad(int rb);
        int bad = 0;
        for (int a = 0; a < NB; a++) begin
            if (rb + a >= rd_addr_q.size()) bad++;
            else if (rd_addr_q[rb+a] != a) bad++;
        end
        return bad;
    endfunction

    task automatic load_pattern(input int mode);
        for (int a = 0; a < NB; a++) begin
            if (mode == 0) begin
                ev_re[a] = DW'(a);
                ev_im[a] = DW'(-a);
                od_re[a] = DW'(a + 32'h4000);
                od_im[a] = DW'(-(a + 32'h4000));
            end else begin
                ev_re[a] = DW'($urandom);
                ev_im[a] = DW'($urandom);
                od_re[a] = DW'($urandom);
                od_im[a] = DW'($urandom);
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic run_to_done(input int pct, output bit to);
        int n = 0;
        to = 1'b0;
        while (!done) begin
            if (n >= 30000) begin
                to = 1'b1;
                break;
            end
            ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; start = 1'b0; ready = 1'b0;
        repeat (3) tick;
        checks++;
        if ({busy, done, valid, last, rd_en} !== 5'b0)
            begin errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, valid, last, rd_en}); end
        checks++;
        if ({rd_addr, idx, o_re, o_im} !== '0)
            begin errors++; $display("FAIL reset_data: got addr=%0h idx=%0h re=%0h im=%0h expected 0", rd_addr, idx, o_re, o_im); end
        rst_n = 1'b1;
        repeat (2) tick;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0)
            begin errors++; $display("FAIL reset_idle: got busy=%b valid=%b expected 0 0", busy, valid); end
    endtask

    task automatic test_full_pass;
        int qb, rb, db, lat;
        bit to;
        load_pattern(0);
        ready = 1'b1;
        qb = beat_q.size(); rb = rd_addr_q.size(); db = done_cnt;
        do_start;
        lat = 0;
        while (!valid && lat < 10) begin tick; lat++; end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL first_valid_latency: got %0d expected 2", lat); end
        run_to_done(100, to);
        checks++;
        if (to) begin errors++; $display("FAIL full_timeout: got timeout expected o_done"); end
        repeat (3) tick;
        checks++;
        if (beat_q.size() - qb != NP) begin errors++; $display("FAIL full_count: got %0d expected %0d", beat_q.size() - qb, NP); end
        checks++;
        if (seq_bad(qb) != 0) begin errors++; $display("FAIL full_seq: got %0d bad beats expected 0", seq_bad(qb)); end
        checks++;
        if (rd_bad(rb) != 0 || rd_addr_q.size() - rb != NB)
            begin errors++; $display("FAIL full_reads: got %0d reads, %0d bad expected %0d, 0", rd_addr_q.size() - rb, rd_bad(rb), NB); end
        checks++;
        if (done_cnt - db != 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", done_cnt - db); end
        if (beat_q.size() >= qb + NP) begin
            checks++;
            if (beat_q[qb+NP-1].cyc - beat_q[qb].cyc != NP - 1)
                begin errors++; $display("FAIL full_throughput: got %0d cycles expected %0d", beat_q[qb+NP-1].cyc - beat_q[qb].cyc, NP - 1); end
            checks++;
            if (done_cyc != beat_q[qb+NP-1].cyc + 1)
                begin errors++; $display("FAIL full_done_timing: got cycle %0d expected %0d", done_cyc, beat_q[qb+NP-1].cyc + 1); end
        end else begin
            checks++; errors++;
            $display("FAIL full_short: got %0d beats expected %0d", beat_q.size() - qb, NP);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_random_ready;
        int qb, db, sb;
        bit to;
        load_pattern(1);
        qb = beat_q.size(); db = done_cnt; sb = stab_err;
        do_start;
        run_to_done(30, to);
        ready = 1'b1;
        repeat (3) tick;
        checks++;
        if (to) begin errors++; $display("FAIL rand_timeout: got timeout expected o_done"); end
        checks++;
        if (beat_q.size() - qb != NP) begin errors++; $display("FAIL rand_count: got %0d expected %0d", beat_q.size() - qb, NP); end
        checks++;
        if (seq_bad(qb) != 0) begin errors++; $display("FAIL rand_seq: got %0d bad beats expected 0", seq_bad(qb)); end
        checks++;
        if (stab_err != sb) begin errors++; $display("FAIL rand_stall_stable: got %0d changes expected 0", stab_err - sb); end
        checks++;
        if (max_outst > 4) begin errors++; $display("FAIL rand_occupancy: got %0d expected <=4", max_outst); end
        checks++;
        if (done_cnt - db != 1) begin errors++; $display("FAIL rand_done_count: got %0d expected 1", done_cnt - db); end
    endtask

    task automatic test_no_ready;
        int qb, r0, db;
        bit to;
        load_pattern(1);
        ready = 1'b0;
        qb = beat_q.size(); r0 = rd_cnt; db = done_cnt;
        do_start;
        repeat (40) tick;
        checks++;
        if (rd_cnt - r0 != 1) begin errors++; $display("FAIL noready_reads: got %0d expected 1", rd_cnt - r0); end
        checks++;
        if (valid !== 1'b1 || idx !== '0 || rd_en !== 1'b0)
            begin errors++; $display("FAIL noready_hold: got valid=%b idx=%0d rd_en=%b expected 1 0 0", valid, idx, rd_en); end
        checks++;
        if (o_re !== ev_re[0] || o_im !== ev_im[0])
            begin errors++; $display("FAIL noready_data: got %0h/%0h expected %0h/%0h", o_re, o_im, ev_re[0], ev_im[0]); end
        run_to_done(100, to);
        repeat (3) tick;
        checks++;
        if (to || seq_bad(qb) != 0 || done_cnt - db != 1)
            begin errors++; $display("FAIL noready_finish: got timeout=%0d bad=%0d done=%0d expected 0 0 1", to, seq_bad(qb), done_cnt - db); end
    endtask

    task automatic test_enable_pause;
        int qb, db, n, r1;
        logic [AW:0] i0;
        logic v0;
        bit to;
        load_pattern(1);
        ready = 1'b1;
        qb = beat_q.size(); db = done_cnt;
        do_start;
        n = 0;
        while (beat_q.size() - qb < 200 && n < 5000) begin tick; n++; end
        en = 1'b0;
        i0 = idx; v0 = valid;
        tick;
        r1 = rd_cnt;
        repeat (9) tick;
        checks++;
        if (idx !== i0 || valid !== v0)
            begin errors++; $display("FAIL pause_hold: got idx=%0d valid=%b expected %0d %b", idx, valid, i0, v0); end
        checks++;
        if (rd_cnt != r1 || rd_en !== 1'b0)
            begin errors++; $display("FAIL pause_reads: got %0d reads expected 0", rd_cnt - r1); end
        en = 1'b1;
        run_to_done(100, to);
        repeat (3) tick;
        checks++;
        if (to || seq_bad(qb) != 0 || beat_q.size() - qb != NP)
            begin errors++; $display("FAIL pause_seq: got timeout=%0d bad=%0d beats=%0d expected 0 0 %0d", to, seq_bad(qb), beat_q.size() - qb, NP); end
        checks++;
        if (done_cnt - db != 1) begin errors++; $display("FAIL pause_done_count: got %0d expected 1", done_cnt - db); end
    endtask

    task automatic test_reset_mid;
        int qb, db, n;
        bit to;
        load_pattern(1);
        ready = 1'b1;
        qb = beat_q.size();
        do_start;
        n = 0;
        while (beat_q.size() - qb < 300 && n < 5000) begin tick; n++; end
        checks++;
        if (n >= 5000) begin errors++; $display("FAIL abort_reach_300: got %0d beats expected 300", beat_q.size() - qb); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, valid, last, rd_en} !== 5'b0 || {rd_addr, idx, o_re, o_im} !== '0)
            begin errors++; $display("FAIL abort_outputs: got flags=%b idx=%0d re=%0h expected zero", {busy, done, valid, last, rd_en}, idx, o_re); end
        db = done_cnt;
        repeat (3) tick;
        rst_n = 1'b1;
        repeat (10) tick;
        checks++;
        if (done_cnt != db || busy !== 1'b0 || valid !== 1'b0 || rd_en !== 1'b0)
            begin errors++; $display("FAIL abort_idle: got done=%0d busy=%b valid=%b expected 0 0 0", done_cnt - db, busy, valid); end
        qb = beat_q.size();
        do_start;
        run_to_done(100, to);
        repeat (3) tick;
        checks++;
        if (to || seq_bad(qb) != 0 || beat_q.size() - qb != NP || done_cnt - db != 1)
            begin errors++; $display("FAIL abort_new_pass: got bad=%0d beats=%0d done=%0d expected 0 %0d 1", seq_bad(qb), beat_q.size() - qb, done_cnt - db, NP); end
    endtask

    task automatic test_back_to_back;
        int qb, db, n;
        load_pattern(0);
        ready = 1'b1;
        qb = beat_q.size(); db = done_cnt;
        do_start;
        n = 0;
        while (!done && n < 30000) begin
            start = busy && (n % 97 == 50);
            tick;
            n++;
        end
        start = 1'b0;
        repeat (20) tick;
        checks++;
        if (n >= 30000) begin errors++; $display("FAIL b2b_timeout: got timeout expected o_done"); end
        checks++;
        if (done_cnt - db != 1 || beat_q.size() - qb != NP)
            begin errors++; $display("FAIL b2b_single_pass: got done=%0d beats=%0d expected 1 %0d", done_cnt - db, beat_q.size() - qb, NP); end
        checks++;
        if (seq_bad(qb) != 0 || busy !== 1'b0)
            begin errors++; $display("FAIL b2b_seq: got bad=%0d busy=%b expected 0 0", seq_bad(qb), busy); end
    endtask

    initial begin
        test_reset;
        test_full_pass;
        test_random_ready;
        test_no_ready;
        test_enable_pause;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
